// File: rtl/conv_window_scheduler.sv
// Raster-order scheduler driving one shared serial MAC unit over every filter window.
// Optional stall statistics port compiled in with `define CONV_SCHED_PERF_EN.
module conv_window_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int F          = 2,
    parameter int H          = 4,
    parameter int W          = 4,
    parameter int S          = 1,
    parameter int PE_LAT     = 2,
    localparam int RW        = $clog2(H),
    localparam int CW        = $clog2(W)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic                  conv_rst,
    output logic [RW-1:0]         win_row,
    output logic [CW-1:0]         win_col,
    input  logic [DATA_WIDTH-1:0] conv_res,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [RW+CW-1:0]      res_idx,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  busy,
`ifdef CONV_SCHED_PERF_EN
    output logic [31:0]           stall_cnt,
`endif
    output logic                  done
);

    localparam int ACC   = D * F * F + PE_LAT;
    localparam int CNT_W = ($clog2(ACC) > 1) ? $clog2(ACC) : 1;
    localparam int IW    = RW + CW;

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(1);
    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACC - 1);
    localparam logic [RW-1:0]    ROW_LAST = RW'(H - F);
    localparam logic [CW-1:0]    COL_LAST = CW'(W - F);
    localparam logic [RW-1:0]    ROW_STEP = RW'(S);
    localparam logic [CW-1:0]    COL_STEP = CW'(S);
    localparam logic [IW-1:0]    IDX_ONE  = IW'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_ACCUM   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_EMIT    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [RW-1:0]         r_row;
    logic [CW-1:0]         r_col;
    logic [IW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_conv_rst;
    logic                  r_busy;
    logic                  r_done;

    logic w_last_win;
    logic w_accept;
    logic w_start_ok;

    assign w_last_win = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_accept   = r_valid && res_ready;
    assign w_start_ok = (r_state == ST_IDLE) && start && !abort;

    // Main sequencer: window walk, MAC reset pulse, accumulate wait and result handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= CNT_ZERO;
            r_row      <= '0;
            r_col      <= '0;
            r_idx      <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_conv_rst <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (abort && (r_state != ST_IDLE)) begin
            // A pending result is simply dropped; no completion is signalled.
            r_state    <= ST_IDLE;
            r_cnt      <= CNT_ZERO;
            r_valid    <= 1'b0;
            r_conv_rst <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_conv_rst <= 1'b1;
                    r_done     <= 1'b0;
                    if (w_start_ok) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= CNT_ZERO;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == CLR_LAST) begin
                        r_state    <= ST_ACCUM;
                        r_cnt      <= CNT_ZERO;
                        r_conv_rst <= 1'b0;
                    end else begin
                        r_cnt      <= r_cnt + CNT_ONE;
                    end
                end
                ST_ACCUM: begin
                    if (r_cnt == ACC_LAST) begin
                        r_state <= ST_CAPTURE;
                        r_cnt   <= CNT_ZERO;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                ST_CAPTURE: begin
                    r_data  <= conv_res;
                    r_valid <= 1'b1;
                    r_state <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (w_accept) begin
                        r_valid    <= 1'b0;
                        r_conv_rst <= 1'b1;
                        if (w_last_win) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            // Window address moves only here, i.e. on entry to CLEAR.
                            r_state <= ST_CLEAR;
                            r_cnt   <= CNT_ZERO;
                            r_idx   <= r_idx + IDX_ONE;
                            if (r_col == COL_LAST) begin
                                r_col <= '0;
                                r_row <= r_row + ROW_STEP;
                            end else begin
                                r_col <= r_col + COL_STEP;
                            end
                        end
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_cnt      <= CNT_ZERO;
                    r_valid    <= 1'b0;
                    r_conv_rst <= 1'b1;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of result cycles stalled by the consumer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= 32'd0;
        end else if (w_start_ok) begin
            r_stall_cnt <= 32'd0;
        end else if ((r_state == ST_EMIT) && !res_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign conv_rst  = r_conv_rst;
    assign win_row   = r_row;
    assign win_col   = r_col;
    assign res_data  = r_data;
    assign res_idx   = r_idx;
    assign res_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Scoreboard bench for conv_window_scheduler: three configurations share clock and reset.
module tb_conv_window_scheduler;

    typedef struct {
        logic [15:0] d;
        logic [7:0]  idx;
        logic [7:0]  row;
        logic [7:0]  col;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic abort = 1'b0;
    logic res_ready = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

    // A: H=W=4 F=2 S=2 ; B: H=W=F=2 ; C: H=W=4 F=2 S=1
    logic        conv_rst_a, res_valid_a, busy_a, done_a;
    logic [1:0]  win_row_a, win_col_a;
    logic [3:0]  res_idx_a;
    logic [15:0] res_data_a, conv_a;
    logic        conv_rst_b, res_valid_b, busy_b, done_b;
    logic [0:0]  win_row_b, win_col_b;
    logic [1:0]  res_idx_b;
    logic [15:0] res_data_b, conv_b;
    logic        conv_rst_c, res_valid_c, busy_c, done_c;
    logic [1:0]  win_row_c, win_col_c;
    logic [3:0]  res_idx_c;
    logic [15:0] res_data_c, conv_c;
    logic [31:0] stall_a, stall_b, stall_c;

    int n_tests = 0;
    int n_fail  = 0;
    int dn_a = 0, dn_b = 0, dn_c = 0;
    exp_t qa[$], qb[$], qc[$];

    always #5 clk = ~clk;

    // MAC stand-ins: each result is a known function of the window address.
    assign conv_a = {12'h010, win_row_a, win_col_a};
    assign conv_b = 16'h0ABC;
    assign conv_c = (16'(win_row_c) * 16'd3 + 16'(win_col_c)) * 16'd3;

    conv_window_scheduler #(.DATA_WIDTH(16), .D(1), .F(2), .H(4), .W(4), .S(2), .PE_LAT(2)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort), .conv_rst(conv_rst_a),
        .win_row(win_row_a), .win_col(win_col_a), .conv_res(conv_a), .res_data(res_data_a),
        .res_idx(res_idx_a), .res_valid(res_valid_a), .res_ready(res_ready), .busy(busy_a),
`ifdef CONV_SCHED_PERF_EN
        .stall_cnt(stall_a),
`endif
        .done(done_a));

    conv_window_scheduler #(.DATA_WIDTH(16), .D(1), .F(2), .H(2), .W(2), .S(1), .PE_LAT(2)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort), .conv_rst(conv_rst_b),
        .win_row(win_row_b), .win_col(win_col_b), .conv_res(conv_b), .res_data(res_data_b),
        .res_idx(res_idx_b), .res_valid(res_valid_b), .res_ready(res_ready), .busy(busy_b),
`ifdef CONV_SCHED_PERF_EN
        .stall_cnt(stall_b),
`endif
        .done(done_b));

    conv_window_scheduler #(.DATA_WIDTH(16), .D(1), .F(2), .H(4), .W(4), .S(1), .PE_LAT(2)) u_c (
        .clk(clk), .reset(reset), .start(start_c), .abort(abort), .conv_rst(conv_rst_c),
        .win_row(win_row_c), .win_col(win_col_c), .conv_res(conv_c), .res_data(res_data_c),
        .res_idx(res_idx_c), .res_valid(res_valid_c), .res_ready(res_ready), .busy(busy_c),
`ifdef CONV_SCHED_PERF_EN
        .stall_cnt(stall_c),
`endif
        .done(done_c));

`ifndef CONV_SCHED_PERF_EN
    assign stall_a = 32'd0;
    assign stall_b = 32'd0;
    assign stall_c = 32'd0;
`endif

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit sel(input int w);
        case (w)
            0: return done_a;
            1: return done_b;
            2: return done_c;
            3: return res_valid_a;
            4: return res_valid_b;
            5: return !conv_rst_a && (win_row_a == 2'd2) && (win_col_a == 2'd0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int w, input string nm, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sel(w)) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, event required", nm, budget);
        end
    endtask

    task automatic pulse_start(input int w);
        @(posedge clk); #1;
        case (w)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    task automatic push_a4();
        qa.push_back('{16'h0100, 8'd0, 8'd0, 8'd0});
        qa.push_back('{16'h0102, 8'd1, 8'd0, 8'd2});
        qa.push_back('{16'h0108, 8'd2, 8'd2, 8'd0});
        qa.push_back('{16'h010A, 8'd3, 8'd2, 8'd2});
    endtask

    // Monitors: compare each newly presented result against the scoreboard head.
    initial begin
        bit seen = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_a) dn_a++;
            if (!res_valid_a) seen = 1'b0;
            else if (!seen) begin
                seen = 1'b1;
                if (qa.size() == 0) check("a_unexpected_result", 32'(res_idx_a), 32'hFFFF);
                else begin
                    e = qa.pop_front();
                    check("a_data", 32'(res_data_a), 32'(e.d));
                    check("a_idx", 32'(res_idx_a), 32'(e.idx));
                    check("a_row", 32'(win_row_a), 32'(e.row));
                    check("a_col", 32'(win_col_a), 32'(e.col));
                end
            end
        end
    end

    initial begin
        bit seen = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_b) dn_b++;
            if (!res_valid_b) seen = 1'b0;
            else if (!seen) begin
                seen = 1'b1;
                if (qb.size() == 0) check("b_unexpected_result", 32'(res_idx_b), 32'hFFFF);
                else begin
                    e = qb.pop_front();
                    check("b_data", 32'(res_data_b), 32'(e.d));
                    check("b_idx", 32'(res_idx_b), 32'(e.idx));
                end
            end
        end
    end

    initial begin
        bit seen = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_c) dn_c++;
            if (!res_valid_c) seen = 1'b0;
            else if (!seen) begin
                seen = 1'b1;
                if (qc.size() == 0) check("c_unexpected_result", 32'(res_idx_c), 32'hFFFF);
                else begin
                    e = qc.pop_front();
                    check("c_data", 32'(res_data_c), 32'(e.d));
                    check("c_idx", 32'(res_idx_c), 32'(e.idx));
                    check("c_row", 32'(win_row_c), 32'(e.row));
                    check("c_col", 32'(win_col_c), 32'(e.col));
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_conv_rst"}, 32'(conv_rst_a), 32'd1);
        check({tag, "_win_row"}, 32'(win_row_a), 32'd0);
        check({tag, "_win_col"}, 32'(win_col_a), 32'd0);
        check({tag, "_res_data"}, 32'(res_data_a), 32'd0);
        check({tag, "_res_idx"}, 32'(res_idx_a), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid_a), 32'd0);
        check({tag, "_busy"}, 32'(busy_a), 32'd0);
        check({tag, "_done"}, 32'(done_a), 32'd0);
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b1;

        // 1: stride 2, consumer always ready
        res_ready = 1'b1;
        dn_a = 0;
        push_a4();
        pulse_start(0);
        @(negedge clk);
        check("t1_busy_running", 32'(busy_a), 32'd1);
        wait_for(0, "t1_done", 200);
        repeat (3) @(negedge clk);
        check("t1_done_once", 32'(dn_a), 32'd1);
        check("t1_busy_after", 32'(busy_a), 32'd0);
        check("t1_queue_empty", 32'(qa.size()), 32'd0);

        // 2: five stalled cycles on idx 1
        dn_a = 0;
        push_a4();
        pulse_start(0);
        wait_for(3, "t2_first_valid", 40);
        @(posedge clk); #1;
        res_ready = 1'b0;
        wait_for(3, "t2_second_valid", 40);
        for (int k = 0; k < 6; k++) begin
            check("t2_hold_valid", 32'(res_valid_a), 32'd1);
            check("t2_hold_idx", 32'(res_idx_a), 32'd1);
            check("t2_hold_data", 32'(res_data_a), 32'h0102);
            if (k < 5) @(negedge clk);
        end
        #1 res_ready = 1'b1;
        wait_for(0, "t2_done", 200);
        repeat (3) @(negedge clk);
        check("t2_done_once", 32'(dn_a), 32'd1);
        check("t2_queue_empty", 32'(qa.size()), 32'd0);
`ifdef CONV_SCHED_PERF_EN
        check("t2_stall_cnt", stall_a, 32'd5);
`endif

        // 3: single window, latency from the sampling edge of start
        dn_b = 0;
        qb.push_back('{16'h0ABC, 8'd0, 8'd0, 8'd0});
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (res_valid_b) break;
            @(posedge clk);
            lat++;
        end
        check("t3_latency", 32'(lat), 32'd9);
        wait_for(1, "t3_done", 40);
        repeat (3) @(negedge clk);
        check("t3_done_once", 32'(dn_b), 32'd1);
        check("t3_busy_after", 32'(busy_b), 32'd0);
        check("t3_queue_empty", 32'(qb.size()), 32'd0);

        // 4: abort during ACCUM of window 2, then a clean rerun
        dn_a = 0;
        qa.push_back('{16'h0100, 8'd0, 8'd0, 8'd0});
        qa.push_back('{16'h0102, 8'd1, 8'd0, 8'd2});
        pulse_start(0);
        wait_for(5, "t4_reach_win2", 100);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("t4_valid_after_abort", 32'(res_valid_a), 32'd0);
        check("t4_busy_after_abort", 32'(busy_a), 32'd0);
        check("t4_conv_rst_after_abort", 32'(conv_rst_a), 32'd1);
        repeat (20) @(negedge clk);
        check("t4_no_done", 32'(dn_a), 32'd0);
        check("t4_queue_empty", 32'(qa.size()), 32'd0);
        push_a4();
        pulse_start(0);
        wait_for(0, "t4_rerun_done", 200);
        repeat (3) @(negedge clk);
        check("t4_rerun_done_once", 32'(dn_a), 32'd1);
        check("t4_rerun_queue_empty", 32'(qa.size()), 32'd0);

        // 5: asynchronous reset while a result is held
        dn_a = 0;
        res_ready = 1'b0;
        qa.push_back('{16'h0100, 8'd0, 8'd0, 8'd0});
        pulse_start(0);
        wait_for(3, "t5_valid", 40);
        #1 reset = 1'b0;
        #1 check_reset_vals("t5_in_reset");
        @(negedge clk);
        check_reset_vals("t5_held");
        #1 reset = 1'b1;
        res_ready = 1'b1;
        push_a4();
        pulse_start(0);
        wait_for(0, "t5_done", 200);
        repeat (3) @(negedge clk);
        check("t5_done_once", 32'(dn_a), 32'd1);
        check("t5_queue_empty", 32'(qa.size()), 32'd0);

        // 6: stride 1, nine windows in raster order
        dn_c = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                qc.push_back('{16'((r * 3 + c) * 3), 8'(r * 3 + c), 8'(r), 8'(c)});
        pulse_start(2);
        wait_for(2, "t6_done", 300);
        repeat (3) @(negedge clk);
        check("t6_done_once", 32'(dn_c), 32'd1);
        check("t6_busy_after", 32'(busy_c), 32'd0);
        check("t6_queue_empty", 32'(qc.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
